// File: rtl/memwb_writeback_stage.sv
// MEM/WB pipeline register plus register-file write-data select; 1-cycle latency.
// No stall or backpressure: the register loads every cycle and the select is combinational from it.
module memwb_writeback_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [4:0]        WB_MEM,
    input  logic [DATA_W-1:0] MEM_ALU_RESULT,
    input  logic [DATA_W-1:0] MEM_RD_DATA,
    input  logic [REG_AW-1:0] MEM_RD,
    input  logic [DATA_W-1:0] MEM_PC_4,
    output logic [2:0]        WB,
    output logic [DATA_W-1:0] WB_ALU_RESULT,
    output logic [DATA_W-1:0] WB_RD_Data,
    output logic [REG_AW-1:0] WB_RD,
    output logic [DATA_W-1:0] WB_PC_4,
    output logic [DATA_W-1:0] WB_RD_DATA
);

    logic [2:0]        wb_d,  wb_q;
    logic [DATA_W-1:0] alu_d, alu_q;
    logic [DATA_W-1:0] mrd_d, mrd_q;
    logic [REG_AW-1:0] rd_d,  rd_q;
    logic [DATA_W-1:0] pc4_d, pc4_q;
    logic [1:0]        unused_mem_ctrl;

    // MEM-stage-only controls stop at this boundary.
    assign unused_mem_ctrl = WB_MEM[1:0];

    assign wb_d  = WB_MEM[4:2];
    assign alu_d = MEM_ALU_RESULT;
    assign mrd_d = MEM_RD_DATA;
    assign rd_d  = MEM_RD;
    assign pc4_d = MEM_PC_4;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wb_q  <= '0;
            alu_q <= '0;
            mrd_q <= '0;
            rd_q  <= '0;
            pc4_q <= '0;
        end else begin
            wb_q  <= wb_d;
            alu_q <= alu_d;
            mrd_q <= mrd_d;
            rd_q  <= rd_d;
            pc4_q <= pc4_d;
        end
    end

    // Select depends only on registered state, so MEM inputs never reach the write port mid-cycle.
    always_comb begin
        WB_RD_DATA = '0;
        unique case (wb_q[2:1])
            2'b00:   WB_RD_DATA = alu_q;
            2'b01:   WB_RD_DATA = mrd_q;
            2'b10:   WB_RD_DATA = pc4_q;
            default: WB_RD_DATA = '0;
        endcase
    end

    assign WB            = wb_q;
    assign WB_ALU_RESULT = alu_q;
    assign WB_RD_Data    = mrd_q;
    assign WB_RD         = rd_q;
    assign WB_PC_4       = pc4_q;

endmodule

// File: tb/tb_memwb_writeback_stage.sv
// Randomized and directed bench for the MEM/WB write-back stage against a transaction-level model.
module tb_memwb_writeback_stage;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [4:0]  WB_MEM = '0;
    logic [31:0] MEM_ALU_RESULT = '0;
    logic [31:0] MEM_RD_DATA = '0;
    logic [4:0]  MEM_RD = '0;
    logic [31:0] MEM_PC_4 = '0;
    logic [2:0]  WB;
    logic [31:0] WB_ALU_RESULT;
    logic [31:0] WB_RD_Data;
    logic [4:0]  WB_RD;
    logic [31:0] WB_PC_4;
    logic [31:0] WB_RD_DATA;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    memwb_writeback_stage #(.DATA_W(32), .REG_AW(5)) dut (
        .CLK(CLK), .RESET(RESET), .WB_MEM(WB_MEM),
        .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_RD_DATA(MEM_RD_DATA),
        .MEM_RD(MEM_RD), .MEM_PC_4(MEM_PC_4),
        .WB(WB), .WB_ALU_RESULT(WB_ALU_RESULT), .WB_RD_Data(WB_RD_Data),
        .WB_RD(WB_RD), .WB_PC_4(WB_PC_4), .WB_RD_DATA(WB_RD_DATA)
    );

    always #5 CLK = ~CLK;

    // The transaction the WB stage currently holds: whatever was presented at the last edge.
    typedef struct packed {
        logic [2:0]  memtoreg_regwrite;
        logic [31:0] alu;
        logic [31:0] load;
        logic [4:0]  rd;
        logic [31:0] pc4;
    } txn_t;

    txn_t held = '0;

    always @(posedge CLK or negedge RESET) begin
        if (!RESET) held <= '0;
        else        held <= '{WB_MEM[4:2], MEM_ALU_RESULT, MEM_RD_DATA, MEM_RD, MEM_PC_4};
    end

    function automatic logic [31:0] wr_data(txn_t t);
        if (t.memtoreg_regwrite[2:1] == 2'd0) return t.alu;
        if (t.memtoreg_regwrite[2:1] == 2'd1) return t.load;
        if (t.memtoreg_regwrite[2:1] == 2'd2) return t.pc4;
        return 32'd0;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("m_wb",   {29'd0, WB}, {29'd0, held.memtoreg_regwrite});
            chk("m_alu",  WB_ALU_RESULT, held.alu);
            chk("m_load", WB_RD_Data, held.load);
            chk("m_rd",   {27'd0, WB_RD}, {27'd0, held.rd});
            chk("m_pc4",  WB_PC_4, held.pc4);
            chk("m_wdat", WB_RD_DATA, wr_data(held));
        end
    end

    task automatic drive(input logic [4:0] wbm, input logic [31:0] alu, input logic [31:0] ld,
                         input logic [4:0] rd, input logic [31:0] pc4);
        WB_MEM = wbm; MEM_ALU_RESULT = alu; MEM_RD_DATA = ld; MEM_RD = rd; MEM_PC_4 = pc4;
    endtask

    task automatic drive_rand();
        drive(5'($urandom), $urandom, $urandom, 5'($urandom), $urandom);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_wb"}, {29'd0, WB}, 32'd0);
        chk({nm, "_alu"}, WB_ALU_RESULT, 32'd0);
        chk({nm, "_load"}, WB_RD_Data, 32'd0);
        chk({nm, "_rd"}, {27'd0, WB_RD}, 32'd0);
        chk({nm, "_pc4"}, WB_PC_4, 32'd0);
        chk({nm, "_wdat"}, WB_RD_DATA, 32'd0);
    endtask

    initial begin
        #1;
        chk_all_zero("rst_init");
        cmp_en = 1'b1;
        drive(5'b11111, 32'hdead_beef, 32'h1234_5678, 5'd7, 32'h99);
        @(posedge CLK); #1;
        chk_all_zero("rst_hold_edge");
        @(negedge CLK); #1;
        drive(5'b01110, 32'd1, 32'd2, 5'd10, 32'd0);
        RESET = 1'b1;

        // lw
        @(posedge CLK); #1;
        chk("lw_wb", {29'd0, WB}, 32'b011);
        chk("lw_rd", {27'd0, WB_RD}, 32'd10);
        chk("lw_wdat", WB_RD_DATA, 32'd2);
        drive(5'b00000, 32'd0, 32'd0, 5'd0, 32'd4);
        #2;
        chk("hold_wdat", WB_RD_DATA, 32'd2);
        chk("hold_wb", {29'd0, WB}, 32'b011);
        @(posedge CLK); #1;
        chk("bub_wb", {29'd0, WB}, 32'd0);
        chk("bub_pc4", WB_PC_4, 32'd4);
        chk("bub_wdat", WB_RD_DATA, 32'd0);

        // back-to-back R-type, jal, reserved, lw
        drive(5'b00100, 32'd1, 32'd2, 5'd10, 32'd0);
        @(posedge CLK); #1;
        chk("rt_wb", {29'd0, WB}, 32'b001);
        chk("rt_wdat", WB_RD_DATA, 32'd1);
        drive(5'b10100, 32'd1, 32'd2, 5'd31, 32'h0040_0008);
        @(posedge CLK); #1;
        chk("jal_wb", {29'd0, WB}, 32'b101);
        chk("jal_rd", {27'd0, WB_RD}, 32'd31);
        chk("jal_wdat", WB_RD_DATA, 32'h0040_0008);
        drive(5'b11100, 32'h11, 32'h22, 5'd3, 32'h33);
        @(posedge CLK); #1;
        chk("rsv_wb", {29'd0, WB}, 32'b111);
        chk("rsv_wdat", WB_RD_DATA, 32'd0);
        drive(5'b01111, 32'haaaa, 32'h5555_0001, 5'd17, 32'h40);
        @(posedge CLK); #1;
        chk("lw2_wb", {29'd0, WB}, 32'b011);
        chk("lw2_wdat", WB_RD_DATA, 32'h5555_0001);

        // asynchronous reset mid-cycle with non-zero state
        #2;
        RESET = 1'b0;
        #1;
        chk_all_zero("rst_async");
        @(negedge CLK); #2;
        drive(5'b00000, 32'd0, 32'd0, 5'd0, 32'd0);
        RESET = 1'b1;
        @(posedge CLK); #1;
        chk_all_zero("rst_release_bubble");

        for (int i = 0; i < 400; i++) begin
            drive_rand();
            if ($urandom_range(0, 39) == 0) begin
                #1;
                RESET = 1'b0;
                #1;
                chk("rnd_rst_wdat", WB_RD_DATA, 32'd0);
                @(negedge CLK); #2;
                RESET = 1'b1;
            end else if ($urandom_range(0, 2) == 0) begin
                #2;
                drive_rand();
            end
            @(posedge CLK); #1;
        end

        @(negedge CLK); #1;
        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
